divide_inverse: RTL and testbench

Sequential unsigned shift-add multiply-accumulate unit that reconstructs a dividend from a divider's output triple: P = Q·B + R. It is the companion of the group's restoring divider. It is used to self-check divider results and to rebuild operands in lab datapaths. It processes one multiplier bit per clock, and a start/done handshake frames each operation.

---
 rtl/divide_inverse_pkg.sv | 18 +
 rtl/divide_inverse_if.sv | 27 ++
 rtl/divide_inverse.sv | 105 ++++++++++
 tb/tb_divide_inverse.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/divide_inverse_pkg.sv
// Shared types and constants for the divide_inverse shift-add reconstructor.
package divide_inverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_W     = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_W);

  // Iteration counter width for a given operand width (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divide_inverse_if.sv
// Operand/result bundle between a requester and divide_inverse.
interface divide_inverse_if
  import divide_inverse_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
);

  logic           start;
  logic [W-1:0]   Q;
  logic [W-1:0]   B;
  logic [W-1:0]   R;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;
  logic           err;

  modport master (
    output start, Q, B, R,
    input  busy, done, P, err
  );

  modport slave (
    input  start, Q, B, R,
    output busy, done, P, err
  );

endinterface

// File: rtl/divide_inverse.sv
// divide_inverse: rebuilds a dividend P = Q*B + R, one multiplier bit per clock.
// Optional build macro: DIV_CHECK_EN flags triples a correct divider cannot emit
// (B == 0 or R >= B); when undefined err is tied low and no comparator exists.
module divide_inverse
  import divide_inverse_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             reset,
  divide_inverse_if.slave  bus
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = cnt_width(W);

  state_e           state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [W-1:0]     mplier_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    p_q;
  logic [PW-1:0]    acc_d;

  // Conditional accumulate; the carry-out cannot be set since Q*B+R < 2^(2W).
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

`ifdef DIV_CHECK_EN
  logic err_next_q;
  logic err_q;
`endif

  // Control FSM and shift-add datapath with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
`ifdef DIV_CHECK_EN
      err_next_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q    <= PW'(bus.R);
            mcand_q  <= PW'(bus.B);
            mplier_q <= bus.Q;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef DIV_CHECK_EN
            err_next_q <= (bus.B == '0) || (bus.R >= bus.B);
`endif
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(W - 1)) begin
            p_q     <= acc_d;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef DIV_CHECK_EN
            err_q <= err_next_q;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;
`ifdef DIV_CHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_divide_inverse.sv
// Self-checking bench for divide_inverse: scoreboard of expected P/err per operation.
module tb_divide_inverse;
  import divide_inverse_pkg::*;

  localparam int unsigned W = DEFAULT_W;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic           err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  divide_inverse_if #(.W(W)) bus ();

  divide_inverse #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [W-1:0] b, input logic [W-1:0] r);
`ifdef DIV_CHECK_EN
    return (b == '0) || (r >= b);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one operation, then track busy/done edge by edge relative to edge 0.
  // restart_edge > 1 re-asserts start (Q=0xFF) so it is sampled at that edge.
  task automatic run_op(input string name, input logic [W-1:0] q, input logic [W-1:0] b,
                        input logic [W-1:0] r, input int restart_edge);
    exp_t cur;
    int   done_edge;
    int   done_cnt;
    cur.p   = (2*W)'(q) * (2*W)'(b) + (2*W)'(r);
    cur.err = exp_err(b, r);
    sb.push_back(cur);
    done_edge = -1;
    done_cnt  = 0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.Q     = q;
    bus.B     = b;
    bus.R     = r;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, "_busy_e0"}, 32'(bus.busy), 32'd1);

    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (restart_edge > 1 && k == restart_edge - 1) begin
        bus.start = 1'b1;
        bus.Q     = 8'hFF;
      end
      if (k < int'(W)) begin
        check({name, "_busy_run"}, 32'(bus.busy), 32'd1);
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
        if (sb.size() == 0) begin
          check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({name, "_P"}, 32'(bus.P), 32'(e.p));
          check({name, "_err"}, 32'(bus.err), 32'(e.err));
          check({name, "_busy_eW"}, 32'(bus.busy), 32'd1);
        end
      end
      if (k == int'(W) + 1) begin
        check({name, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({name, "_done_off"}, 32'(bus.done), 32'd0);
        check({name, "_P_hold"}, 32'(bus.P), 32'(cur.p));
        check({name, "_err_hold"}, 32'(bus.err), 32'(cur.err));
      end
    end
    bus.start = 1'b0;
    check({name, "_latency"}, 32'(done_edge), 32'(W));
    check({name, "_ndone"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.Q     = '0;
    bus.B     = '0;
    bus.R     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_P",    32'(bus.P),    32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    reset = 1'b0;

    run_op("roundtrip", 8'h1C, 8'h07, 8'h04, 0);
    run_op("extremes",  8'hFF, 8'hFF, 8'hFE, 0);
    run_op("zero_q",    8'h00, 8'h10, 8'h03, 0);
    run_op("restart",   8'h03, 8'h05, 8'h01, 3);

    // Reset sampled at edge 4 aborts the operation with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.Q     = 8'h55;
    bus.B     = 8'h33;
    bus.R     = 8'h01;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("abort_done_pre", 32'(bus.done), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_P",    32'(bus.P),    32'd0);
    check("abort_err",  32'(bus.err),  32'd0);
    run_op("post_rst", 8'h02, 8'h09, 8'h00, 0);

    // start coincident with reset is dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1;
    reset     = 1'b1;
    bus.Q     = 8'h03;
    bus.B     = 8'h03;
    bus.R     = 8'h00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("rst_start_busy2", 32'(bus.busy), 32'd0);
    check("rst_start_P",     32'(bus.P),    32'd0);

    run_op("chk_r_ge_b", 8'h02, 8'h05, 8'h07, 0);
    run_op("chk_b_zero", 8'h04, 8'h00, 8'h03, 0);
    run_op("chk_valid",  8'h1C, 8'h07, 8'h04, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
